// File: rtl/updown_counter_ctl.sv
// Programmable up/down counter with limit, step, load, wrap/saturate, terminal-count
// pulse and a run/stop/one-shot FSM; state updates on the falling edge of clk.
// Optional tick prescaler enabled by defining UDC_PRESCALE_EN.
module updown_counter_ctl #(
  parameter int N      = 10,
  parameter int STEP_W = 4
`ifdef UDC_PRESCALE_EN
  ,
  parameter int PRESCALE_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  input  logic              oneshot,
  input  logic              sat,
  input  logic              load,
  input  logic [N-1:0]      load_val,
  input  logic [N-1:0]      limit,
  input  logic [STEP_W-1:0] step,
`ifdef UDC_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [N-1:0]      Q,
  output logic              tc,
  output logic              busy,
  output logic              done
);

  localparam int NX = N + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   q_q, q_d;
  logic           tc_q, tc_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           qual, tick;
  logic [NX-1:0]  qx, lx, sx, l1, sum, wrap_up, wrap_dn;

  assign qual = (state_q == RUN) && en && !load;

`ifdef UDC_PRESCALE_EN
  logic [PRESCALE_W-1:0] pre_q, pre_d;

  // >= rather than == so a shrinking prescale never forces a full rollover
  always_comb begin
    pre_d = pre_q;
    tick  = qual && (pre_q >= prescale);
    if (load || start) begin
      pre_d = '0;
    end else if (qual) begin
      pre_d = (pre_q >= prescale) ? '0 : pre_q + PRESCALE_W'(1);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end
`else
  assign tick = qual;
`endif

  // Extra bit keeps Q+S and Q+L1-S free of overflow
  always_comb begin
    qx      = NX'(q_q);
    lx      = NX'(limit);
    sx      = NX'(step);
    l1      = lx + NX'(1);
    sum     = qx + sx;
    wrap_up = sum - l1;
    wrap_dn = qx + l1 - sx;
  end

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (tick) begin
      if (qx > lx) begin
        q_d  = mode ? '0 : limit;
        tc_d = 1'b1;
      end else if (sx == '0) begin
        q_d = q_q;
      end else if (mode) begin
        if (sum <= lx) begin
          q_d = sum[N-1:0];
        end else begin
          tc_d = 1'b1;
          if (sat)                q_d = limit;
          else if (wrap_up > lx)  q_d = '0;
          else                    q_d = wrap_up[N-1:0];
        end
      end else begin
        if (qx >= sx) begin
          q_d = q_q - N'(step);
        end else begin
          tc_d = 1'b1;
          if (sat)                q_d = '0;
          else if (wrap_dn > lx)  q_d = limit;
          else                    q_d = wrap_dn[N-1:0];
        end
      end
    end
  end

  // Load freezes the FSM; stop outranks a same-cycle terminal event
  always_comb begin
    state_d = state_q;
    if (!load) begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN: begin
          if (stop)                  state_d = IDLE;
          else if (tc_d && oneshot)  state_d = DONE;
        end
        DONE: begin
          if (start)     state_d = RUN;
          else if (stop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_updown_counter_ctl.sv
// Scoreboard bench for updown_counter_ctl: stimulus queues expected outputs,
// a monitor compares them after each falling edge (or immediately on reset).
module tb_updown_counter_ctl;

  localparam int N      = 10;
  localparam int STEP_W = 4;
  localparam int PW     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0, mode = 1'b1, start = 1'b0, stop = 1'b0;
  logic              oneshot = 1'b0, sat = 1'b0, load = 1'b0;
  logic [N-1:0]      load_val = '0;
  logic [N-1:0]      limit = 10'd1023;
  logic [STEP_W-1:0] step = 4'd1;
  logic [PW-1:0]     prescale = '0;
  logic [N-1:0]      Q;
  logic              tc, busy, done;

  typedef struct {
    string        name;
    logic [N-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  updown_counter_ctl #(
    .N(N),
    .STEP_W(STEP_W)
`ifdef UDC_PRESCALE_EN
    ,
    .PRESCALE_W(PW)
`endif
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start), .stop(stop),
    .oneshot(oneshot), .sat(sat), .load(load), .load_val(load_val),
    .limit(limit), .step(step),
`ifdef UDC_PRESCALE_EN
    .prescale(prescale),
`endif
    .Q(Q), .tc(tc), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  // Monitor: outputs are valid after each falling edge, or right after rst rises
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({Q, tc, busy, done} !== {e.q, e.tc, e.busy, e.done}) begin
          errors++;
          $display("FAIL %s: got Q=%0d tc=%b busy=%b done=%b, expected Q=%0d tc=%b busy=%b done=%b",
                   e.name, Q, tc, busy, done, e.q, e.tc, e.busy, e.done);
        end
      end
    end
  end

  // Inputs are already driven for this cycle; queue expectation and advance
  task automatic cyc(input string name, input int eq, input logic etc,
                     input logic eb, input logic ed);
    exp_t e;
    e.name = name; e.q = N'(eq); e.tc = etc; e.busy = eb; e.done = ed;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    @(posedge clk);
    rst = 1'b1;  cyc("reset_state", 0, 0, 0, 0);
    rst = 1'b0;  cyc("reset_release", 0, 0, 0, 0);

    // Reset mid-run
    start = 1;   cyc("mid_start", 0, 0, 1, 0);
    start = 0; en = 1;
    for (int i = 1; i <= 5; i++) cyc("mid_count", i, 0, 1, 0);
    rst = 1;     cyc("mid_reset_async", 0, 0, 0, 0);
    rst = 0; en = 0;
    cyc("mid_reset_idle", 0, 0, 0, 0);

    // Up-wrap: limit 9 step 3 from 8
    limit = 9; step = 3; sat = 0; mode = 1;
    load = 1; load_val = 8; cyc("wrap_load_idle", 8, 0, 0, 0);
    load = 0; start = 1;    cyc("wrap_start", 8, 0, 1, 0);
    start = 0; en = 1;      cyc("up_wrap", 1, 1, 1, 0);
    cyc("up_after_wrap", 4, 0, 1, 0);
    en = 0; stop = 1;       cyc("wrap_stop", 4, 0, 0, 0);
    stop = 0;

    // Down-saturate: limit 100 step 4 from 2
    limit = 100; step = 4; sat = 1; mode = 0;
    load = 1; load_val = 2; cyc("dsat_load", 2, 0, 0, 0);
    load = 0; start = 1;    cyc("dsat_start", 2, 0, 1, 0);
    start = 0; en = 1;      cyc("down_sat", 0, 1, 1, 0);
    cyc("down_sat_hold1", 0, 1, 1, 0);
    cyc("down_sat_hold2", 0, 1, 1, 0);
    en = 0;                 cyc("down_sat_en0", 0, 0, 1, 0);
    // Down-wrap, zero step, stop with concurrent count
    limit = 9; step = 3; sat = 0;
    load = 1; load_val = 1; cyc("dwrap_load", 1, 0, 1, 0);
    load = 0; en = 1;       cyc("down_wrap", 8, 1, 1, 0);
    cyc("down_after_wrap", 5, 0, 1, 0);
    step = 0;               cyc("step_zero_hold", 5, 0, 1, 0);
    step = 3; stop = 1;     cyc("stop_with_tick", 2, 0, 0, 0);
    stop = 0; en = 0;

    // One-shot: limit 3 up step 1 from 0
    oneshot = 1; limit = 3; step = 1; mode = 1;
    load = 1; load_val = 0; cyc("os_load", 0, 0, 0, 0);
    load = 0; start = 1;    cyc("os_start", 0, 0, 1, 0);
    start = 0; en = 1;
    for (int i = 1; i <= 3; i++) cyc("os_count", i, 0, 1, 0);
    cyc("os_terminal_done", 0, 1, 0, 1);
    cyc("os_done_hold", 0, 0, 0, 1);
    start = 1;              cyc("os_restart", 0, 0, 1, 0);
    start = 0;
    for (int i = 1; i <= 3; i++) cyc("os_count2", i, 0, 1, 0);
    cyc("os_terminal2", 0, 1, 0, 1);
    start = 1; stop = 1;    cyc("os_start_wins", 0, 0, 1, 0);
    start = 0; en = 0;      cyc("os_stop_run", 0, 0, 0, 0);
    stop = 0; oneshot = 0;

    // Load priority and out-of-range
    limit = 20; mode = 1; step = 1;
    start = 1;              cyc("oor_start", 0, 0, 1, 0);
    start = 0; en = 1; load = 1; load_val = 50;
    cyc("oor_load", 50, 0, 1, 0);
    load = 0;               cyc("oor_up", 0, 1, 1, 0);
    load = 1;               cyc("oor_reload_tc0", 50, 0, 1, 0);
    load = 0; mode = 0;     cyc("oor_down", 20, 1, 1, 0);
    // Up saturate at limit
    sat = 1; mode = 1; step = 7;
    cyc("up_sat_hold1", 20, 1, 1, 0);
    cyc("up_sat_hold2", 20, 1, 1, 0);
    load = 1; load_val = 18; cyc("up_sat_load", 18, 0, 1, 0);
    load = 0;               cyc("up_sat_clip", 20, 1, 1, 0);
    // Wrap results still beyond limit
    sat = 0; limit = 2; step = 15;
    load = 1; load_val = 1; cyc("big_load", 1, 0, 1, 0);
    load = 0;               cyc("up_wrap_clamp0", 0, 1, 1, 0);
    load = 1;               cyc("big_reload", 1, 0, 1, 0);
    load = 0; mode = 0;     cyc("down_wrap_clamp_lim", 2, 1, 1, 0);
    en = 0; stop = 1;       cyc("big_stop", 2, 0, 0, 0);
    stop = 0;

`ifdef UDC_PRESCALE_EN
    prescale = 2; limit = 1023; step = 1; mode = 1;
    load = 1; load_val = 0; cyc("ps_load", 0, 0, 0, 0);
    load = 0; start = 1;    cyc("ps_start", 0, 0, 1, 0);
    start = 0; en = 1;
    cyc("ps_wait1", 0, 0, 1, 0);
    cyc("ps_wait2", 0, 0, 1, 0);
    cyc("ps_tick1", 1, 0, 1, 0);
    cyc("ps_wait3", 1, 0, 1, 0);
    load = 1; load_val = 7; cyc("ps_load_mid", 7, 0, 1, 0);
    load = 0;
    cyc("ps_wait4", 7, 0, 1, 0);
    cyc("ps_wait5", 7, 0, 1, 0);
    cyc("ps_tick2", 8, 0, 1, 0);
    en = 0; prescale = 0;
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_counter_ctl.md
Name: updown_counter_ctl

Overview:
Second-generation parametrised up/down counter for timing and address-sequencing datapaths.
- Adds a programmable limit (counts modulo limit+1), a programmable step, parallel load, and wrap or saturate selection.
- Adds a terminal-count pulse and a run/stop/one-shot control FSM.
- All state updates on the falling edge of clk, consistent with the other counters in the datapath.

Parameters:
N, 10, counter width in bits
STEP_W, 4, width of the step input

Ports:
clk  in  1  clock; state updates on falling edge
rst  in  1  asynchronous reset, active-high
en  in  1  count enable; counting occurs only when en=1 and FSM is in RUN
mode  in  1  direction: 1 = up, 0 = down
start  in  1  IDLE/DONE -> RUN
stop  in  1  RUN -> IDLE
oneshot  in  1  1 = stop in DONE at first terminal event; 0 = free-running
sat  in  1  1 = saturate at bounds; 0 = wrap
load  in  1  synchronous parallel load
load_val  in  N  value loaded when load=1
limit  in  N  upper bound; legal range is [0, limit]
step  in  STEP_W  increment/decrement magnitude, zero-extended
Q  out  N  counter value
tc  out  1  terminal-count pulse, one cycle
busy  out  1  FSM in RUN
done  out  1  FSM in DONE

Behaviour:
- Reset (asynchronous): Q=0, state=IDLE, tc=0, busy=0, done=0. Reset mid-count aborts immediately with no tc.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN.
  - RUN: stop=1 -> IDLE (stop has priority over a terminal event in the same cycle; Q still updates that cycle); terminal event with oneshot=1 -> DONE; otherwise stay in RUN.
  - DONE: start=1 -> RUN; stop=1 -> IDLE; if both are asserted, start wins.
- Priority per falling edge: load > count. load=1 sets Q=load_val in any state, leaves state unchanged, tc=0.
- Count tick: state=RUN, en=1, load=0. Arithmetic is done in N+1 bits. Let L1=limit+1 and S=step.
  - Out-of-range start (Q>limit at a tick): Q <- 0 if up, Q <- limit if down; tc=1.
  - Up, Q+S<=limit: Q <- Q+S.
  - Up, Q+S>limit: if sat, Q <- limit; else Q <- Q+S-L1, and if that result is still >limit, Q <- 0. tc=1.
  - Down, Q>=S: Q <- Q-S.
  - Down, Q<S: if sat, Q <- 0; else Q <- Q+L1-S, and if that result is still >limit, Q <- limit. tc=1.
  - Saturated hold: when Q is already at the bound in the count direction (sat=1), Q holds and tc=1 on every tick.
  - S=0: Q holds, tc=0.
- tc is registered and high for exactly the cycle following the tick that produced the terminal event. It is 0 otherwise, including on load cycles and in IDLE/DONE.
- busy=1 iff state=RUN. done=1 iff state=DONE. Both are registered alongside the state.
- limit, mode, step and sat may change on any cycle; the new values take effect at the next tick.
- A load_val greater than limit is accepted as-is; the out-of-range rule applies at the next tick.

Optional Feature:
UDC_PRESCALE_EN
- Defined: adds parameter PRESCALE_W (default 8) and input prescale[PRESCALE_W]. A count tick occurs only on every (prescale+1)-th qualifying cycle (RUN, en=1, load=0). The internal prescaler is cleared by rst, load, and start, and holds while en=0. prescale=0 gives identical behaviour to the undefined build.
- Undefined: no prescale port or logic; every qualifying cycle is a tick.

Test Plan:
- Reset mid-run: N=10, start, count up step 1 to Q=5, assert rst -> Q=0, IDLE, tc=0, busy=0 immediately.
- Up-wrap: limit=9, step=3, sat=0, Q=8, one tick -> Q=1, tc=1 for one cycle; next tick -> Q=4, tc=0.
- Down-saturate: limit=100, step=4, sat=1, Q=2 -> Q=0, tc=1; further ticks hold Q=0 with tc=1 each tick.
- One-shot: oneshot=1, limit=3, up step 1 from Q=0 -> Q=1,2,3, then 0 with tc=1, state DONE, done=1; en held high leaves Q=0; start -> RUN, busy=1.
- Load priority and out-of-range: in RUN with en=1, load=1 load_val=50, limit=20 -> Q=50, tc=0; next up tick -> Q=0, tc=1; a down tick instead -> Q=20, tc=1.
- UDC_PRESCALE_EN: prescale=2, en=1, up step 1 from Q=0 -> Q increments every 3rd cycle; load mid-interval restarts the 3-cycle interval.
